// File: rtl/cke_pkg.sv
// Shared types for the clock-enable scheduler.
package cke_pkg;

  typedef enum logic [1:0] {
    CKE_OFF     = 2'd0,
    CKE_PULSE   = 2'd1,
    CKE_SQUARE  = 2'd2,
    CKE_ONESHOT = 2'd3
  } cke_mode_e;

endpackage

// File: rtl/cke_chan.sv
// One enable channel: active config, pending slot, tick counter and output decode.
module cke_chan
  import cke_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         wr,
  input  logic [1:0]   wr_mode,
  input  logic [W-1:0] wr_period,
  output logic         cke,
  output logic         busy,
  output logic         pend
);

  typedef struct packed {
    cke_mode_e    mode;
    logic [W-1:0] period;
  } cke_chan_cfg_t;

  cke_chan_cfg_t act, nxt, wcfg;
  logic [W-1:0]  cnt;
  logic          last, wrap;

  assign wcfg = '{mode: cke_mode_e'(wr_mode), period: wr_period};
  assign last = (cnt == act.period - 1'b1);
  assign wrap = tick && (act.mode != CKE_OFF) && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= '0;
      nxt  <= '0;
      cnt  <= '0;
      pend <= 1'b0;
    end else if (wr && wcfg.mode == CKE_OFF) begin
      act.mode <= CKE_OFF;
      cnt      <= '0;
      pend     <= 1'b0;
    end else if (wr && (act.mode == CKE_OFF || (wrap && act.mode == CKE_ONESHOT))) begin
      // A finishing oneshot would otherwise strand the write in a pending slot that never drains.
      act <= wcfg;
      cnt <= '0;
    end else begin
      if (wr) begin
        pend <= 1'b1;
        nxt  <= wcfg;
      end
      if (wrap) begin
        cnt <= '0;
        if (pend) begin
          act  <= nxt;
          pend <= 1'b0;
        end else if (act.mode == CKE_ONESHOT) begin
          act.mode <= CKE_OFF;
        end
      end else if (tick && act.mode != CKE_OFF) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cke = 1'b0;
    unique case (act.mode)
      CKE_PULSE:   cke = tick && (cnt == '0);
      CKE_SQUARE:  cke = (cnt < (act.period >> 1));
      CKE_ONESHOT: cke = tick && last;
      default:     cke = 1'b0;
    endcase
  end

  assign busy = (act.mode != CKE_OFF);

endmodule

// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler: shared prescaler, config decode, N channels.
module cke_sched
  import cke_pkg::*;
#(
  parameter  int PRESCALE = 50,
  parameter  int N        = 4,
  parameter  int W        = 16,
  localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [1:0]    cfg_mode,
  input  logic [W-1:0]  cfg_period,
  output logic [N-1:0]  cke,
  output logic [N-1:0]  busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef struct packed {
    cke_mode_e    mode;
    logic [W-1:0] period;
  } cke_chan_cfg_t;

  logic [PW-1:0]      pre_cnt;
  logic               tick, acc;
  cke_chan_cfg_t      wcfg;
  logic [N-1:0]       pend;
  logic [2**CW-1:0]   pend_pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            pre_cnt <= '0;
    else if (pre_cnt == PW'(PRESCALE - 1)) pre_cnt <= '0;
    else                                   pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == '0);

  assign wcfg.mode   = cke_mode_e'(cfg_mode);
  assign wcfg.period = (cfg_period == '0) ? W'(1) : cfg_period;

  // Unused decode slots read as "not pending", so out-of-range writes are accepted and dropped.
  always_comb begin
    pend_pad        = '0;
    pend_pad[N-1:0] = pend;
  end

  assign cfg_ready = !pend_pad[cfg_ch];
  assign acc       = cfg_valid && cfg_ready;

  for (genvar i = 0; i < N; i++) begin : g_ch
    cke_chan #(.W(W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr        (acc && (cfg_ch == CW'(i))),
      .wr_mode   (wcfg.mode),
      .wr_period (wcfg.period),
      .cke       (cke[i]),
      .busy      (busy[i]),
      .pend      (pend[i])
    );
  end

endmodule

// File: tb/tb_cke_sched.sv
// Scoreboard bench for cke_sched: expected cke edge cycles are queued per channel when writes are driven.
module tb_cke_sched;
  import cke_pkg::*;

  localparam int P   = 4;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [W-1:0]   cfg_period = '0;
  logic           cfg_ready;
  logic [NCH-1:0] cke, busy;

  logic           b_valid = 1'b0;
  logic [1:0]     b_ch = '0;
  logic [1:0]     b_mode = '0;
  logic [W-1:0]   b_per = '0;
  logic           b_ready;
  logic [2:0]     b_cke, b_busy;

  always #5 clk = ~clk;

  cke_sched #(.PRESCALE(P), .N(NCH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cke(cke), .busy(busy)
  );

  cke_sched #(.PRESCALE(P), .N(3), .W(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_ch(b_ch), .cfg_mode(b_mode), .cfg_period(b_per),
    .cke(b_cke), .busy(b_busy)
  );

  int cyc = 0;
  int e0 = 0;
  int n_chk = 0;
  int n_err = 0;
  int eq[NCH][$];
  logic [NCH-1:0] prev = '0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // The cycle following edge k carries a tick when it is a multiple of P cycles after release.
  function automatic bit is_tick(input int k);
    return ((k - e0 + 1) % P) == 0;
  endfunction

  function automatic int next_tick(input int k);
    int j = k;
    while (!is_tick(j)) j++;
    return j;
  endfunction

  task automatic push_pulse(input int ch, input int c);
    eq[ch].push_back(c);
    eq[ch].push_back(c + 1);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic wr(input int ch, input int mode, input int per, output int acc);
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = W'(per);
    cfg_valid  = 1'b1;
    acc = -1;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (cfg_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (acc < 0) check("write accept timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (cke[i] !== prev[i]) begin
          if (eq[i].size() == 0) check($sformatf("ch%0d unexpected edge", i), cyc, -1);
          else                   check($sformatf("ch%0d edge", i), cyc, eq[i].pop_front());
        end
      end
    end
    prev <= cke;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a, b, t;
    logic [2:0] seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    mon_en = 1'b1;

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      check("idle outputs", int'({cke, busy, cfg_ready}), 1);
    end

    // PULSE period 3: 12-cycle spacing aligned with ticks
    wr(0, CKE_PULSE, 3, a);
    check("ch0 busy after write", busy[0], 1);
    t = next_tick(a);
    push_pulse(0, t); push_pulse(0, t + 12); push_pulse(0, t + 24);
    wait_until(t + 26);
    wr(0, CKE_OFF, 0, b);
    check("ch0 busy after off", busy[0], 0);
    check("ch0 edges left", eq[0].size(), 0);

    // SQUARE period 4, then period 0 (== 1) queued behind it
    wr(1, CKE_SQUARE, 4, a);
    eq[1].push_back(a);
    t = next_tick(a);
    eq[1].push_back(t + 5); eq[1].push_back(t + 13); eq[1].push_back(t + 21);
    wait_until(t + 22);
    wr(1, CKE_SQUARE, 0, b);
    check("ch1 pending accept edge", b, t + 23);
    wait_until(t + 25);
    #1;
    check("ch1 ready while pending", cfg_ready, 0);
    wait_until(t + 30);
    #1;
    check("ch1 ready after wrap", cfg_ready, 1);
    check("ch1 busy at period 1", busy[1], 1);
    wait_until(t + 70);
    check("ch1 period 1 level", cke[1], 0);
    wr(1, CKE_OFF, 0, b);
    check("ch1 busy after off", busy[1], 0);
    check("ch1 edges left", eq[1].size(), 0);

    // ONESHOT period 5
    wr(2, CKE_ONESHOT, 5, a);
    t = next_tick(a);
    push_pulse(2, t + 16);
    wait_until(t + 16);
    check("ch2 busy at fire", busy[2], 1);
    wait_until(t + 17);
    check("ch2 busy after fire", busy[2], 0);
    wait_until(t + 60);
    check("ch2 edges left", eq[2].size(), 0);

    // Running PULSE 3, rewrite PULSE 3 (pending), then PULSE 6 (stalled)
    wr(0, CKE_PULSE, 3, a);
    t = next_tick(a);
    push_pulse(0, t); push_pulse(0, t + 12); push_pulse(0, t + 24); push_pulse(0, t + 48);
    wait_until(t + 1);
    wr(0, CKE_PULSE, 3, b);
    check("ch0 pending accept edge", b, t + 2);
    #1;
    check("ch0 ready while pending", cfg_ready, 0);
    wr(0, CKE_PULSE, 6, b);
    check("ch0 stalled accept edge", b, t + 10);
    wait_until(t + 50);
    wr(0, CKE_OFF, 0, b);
    check("ch0 busy after off 2", busy[0], 0);
    check("ch0 edges left 2", eq[0].size(), 0);

    // PULSE period 0 behaves as period 1: a pulse every tick
    wr(3, CKE_PULSE, 0, a);
    t = next_tick(a);
    push_pulse(3, t); push_pulse(3, t + 4); push_pulse(3, t + 8);
    wait_until(t + 9);
    wr(3, CKE_OFF, 0, b);
    check("ch3 busy after off", busy[3], 0);
    check("ch3 edges left", eq[3].size(), 0);

    // OFF on a running SQUARE drops cke and busy the next cycle
    wr(1, CKE_SQUARE, 2, a);
    eq[1].push_back(a);
    check("ch1 square high", cke[1], 1);
    wr(1, CKE_OFF, 2, b);
    eq[1].push_back(b);
    check("ch1 off accept edge", b, a + 1);
    check("ch1 off outputs", int'({cke[1], busy[1]}), 0);
    repeat (8) @(negedge clk);
    check("ch1 edges left 2", eq[1].size(), 0);

    // Out-of-range channel on a 3-channel instance
    @(negedge clk);
    b_ch = 2'd3; b_mode = 2'(CKE_PULSE); b_per = 8'd1; b_valid = 1'b1;
    #1;
    check("oor ready", b_ready, 1);
    @(negedge clk);
    b_valid = 1'b0;
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen |= b_cke;
    end
    check("oor busy", int'(b_busy), 0);
    check("oor cke", int'(seen), 0);
    b_ch = 2'd2; b_mode = 2'(CKE_SQUARE); b_per = 8'd4; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check("b ch2 busy", int'(b_busy), 4);
    check("b ch2 cke", int'(b_cke), 4);

    // Asynchronous reset mid-run with a write pending
    mon_en = 1'b0;
    wr(1, CKE_SQUARE, 4, a);
    wr(1, CKE_SQUARE, 2, b);
    #1;
    check("ch1 ready pending pre-reset", cfg_ready, 0);
    wr(0, CKE_PULSE, 1, a);
    cfg_ch = 2'd1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset cke", int'(cke), 0);
    check("reset busy", int'(busy), 0);
    check("reset ready", cfg_ready, 1);
    check("reset b busy", int'(b_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    repeat (5) @(negedge clk);
    #1;
    check("post-reset outputs", int'({cke, busy, cfg_ready}), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
